// File: rtl/lcd_ctrl_pkg.sv
// Shared constants for the parametrised LCD controller: command codes, FSM encoding, size helpers.
// No logic; consumed by lcd_ctrl_param and lcd_win_reduce.
// Not applicable: no flow control here.
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE    = 4'd0;
    localparam logic [3:0] CMD_UP       = 4'd1;
    localparam logic [3:0] CMD_DOWN     = 4'd2;
    localparam logic [3:0] CMD_LEFT     = 4'd3;
    localparam logic [3:0] CMD_RIGHT    = 4'd4;
    localparam logic [3:0] CMD_MAX      = 4'd5;
    localparam logic [3:0] CMD_MIN      = 4'd6;
    localparam logic [3:0] CMD_AVE      = 4'd7;
    localparam logic [3:0] CMD_ROT_L    = 4'd8;
    localparam logic [3:0] CMD_ROT_R    = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
    localparam logic [3:0] CMD_ORIGIN   = 4'd12;
    localparam logic [3:0] CMD_INVERT   = 4'd13;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_CMD   = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;
    localparam logic [2:0] ST_STORE = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [1:0] {
        RED_MAX = 2'd0,
        RED_MIN = 2'd1,
        RED_AVE = 2'd2
    } red_op_e;

    function automatic int calc_aw(input int w, input int h);
        return $clog2(w * h);
    endfunction

    function automatic int centre_of(input int dim);
        return dim / 2;
    endfunction

endpackage

// File: rtl/lcd_win_reduce.sv
// Folds the four window pixels (LU, RU, LD, RD) into a max, min or floor-average.
// Latency: 4 cycles from start; result is valid while last=1 (4th cycle).
// No backpressure: once started it runs to completion; op and pixels must stay stable.
module lcd_win_reduce
    import lcd_ctrl_pkg::*;
#(
    parameter int DW = 8
)(
    input  logic          clk,
    input  logic          reset,
    input  red_op_e       op,
    input  logic          start,
    input  logic [DW-1:0] p_lu,
    input  logic [DW-1:0] p_ru,
    input  logic [DW-1:0] p_ld,
    input  logic [DW-1:0] p_rd,
    output logic [DW-1:0] result,
    output logic          last
);

    logic [DW+1:0] acc_q, acc_d;
    logic [1:0]    stg_q, stg_d;
    logic [DW-1:0] px;
    logic [DW+1:0] fold;

    always_comb begin
        case (stg_q)
            2'd1:    px = p_ru;
            2'd2:    px = p_ld;
            default: px = p_rd;
        endcase

        fold = acc_q;
        case (op)
            RED_MAX: if ({2'b00, px} > acc_q) fold = {2'b00, px};
            RED_MIN: if ({2'b00, px} < acc_q) fold = {2'b00, px};
            default: fold = acc_q + {2'b00, px};
        endcase

        acc_d = acc_q;
        stg_d = stg_q;
        if (start) begin
            acc_d = {2'b00, p_lu};
            stg_d = 2'd1;
        end else if (stg_q != 2'd0) begin
            acc_d = fold;
            stg_d = stg_q + 2'd1;
        end
    end

    // The final fold (RD) is not registered: it is handed out combinationally on the 4th cycle.
    assign last   = (stg_q == 2'd3);
    assign result = (op == RED_AVE) ? fold[DW+1:2] : fold[DW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            stg_q <= 2'd0;
        end else begin
            acc_q <= acc_d;
            stg_q <= stg_d;
        end
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Loads an IMG_W x IMG_H image from IROM, applies 2x2-window commands, streams the result to IRAM.
// Latency: N(+1 drain) load cycles; 1 cycle per simple command, 4 for MAX/MIN/AVE; N store cycles.
// Backpressure: busy=1 blocks commands; cmd_valid while busy is dropped, never queued.
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter  int IMG_W   = 8,
    parameter  int IMG_H   = 8,
    parameter  int DW      = 8,
    parameter  int ROM_LAT = 0,
    localparam int N       = IMG_W * IMG_H,
    localparam int AW      = calc_aw(IMG_W, IMG_H)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_CTR    = XW'(centre_of(IMG_W));
    localparam logic [YW-1:0] Y_CTR    = YW'(centre_of(IMG_H));
    localparam logic [XW-1:0] X_MAX    = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(IMG_H - 1);
    localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);
    localparam logic [AW-1:0] ROW      = AW'(IMG_W);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          cap_vld_q, cap_vld_d;
    logic [AW-1:0] cap_addr_q, cap_addr_d;
    logic [DW-1:0] buf_q [0:N-1];
    logic [DW-1:0] buf_d [0:N-1];

    logic [AW-1:0] a_rd, a_ld, a_ru, a_lu;
    logic [DW-1:0] p_rd, p_ld, p_ru, p_lu;
    logic [DW-1:0] n_rd, n_ld, n_ru, n_lu;
    logic          win_wr;
    logic          is_reduce;
    logic          red_start;
    logic          red_last;
    logic [DW-1:0] red_result;
    red_op_e       red_op;

    // Power-of-two width makes y*IMG_W+x a plain concatenation.
    assign a_rd = {y_q, x_q};
    assign a_ld = a_rd - AW'(1);
    assign a_ru = a_rd - ROW;
    assign a_lu = a_ru - AW'(1);

    assign p_rd = buf_q[a_rd];
    assign p_ld = buf_q[a_ld];
    assign p_ru = buf_q[a_ru];
    assign p_lu = buf_q[a_lu];

    assign is_reduce = (cmd_q == CMD_MAX) || (cmd_q == CMD_MIN) || (cmd_q == CMD_AVE);
    assign red_op    = (cmd_q == CMD_MAX) ? RED_MAX :
                       (cmd_q == CMD_MIN) ? RED_MIN : RED_AVE;
    assign red_start = (state_q == ST_EXEC) && is_reduce && (cnt_q == '0);

    lcd_win_reduce #(.DW(DW)) u_reduce (
        .clk    (clk),
        .reset  (reset),
        .op     (red_op),
        .start  (red_start),
        .p_lu   (p_lu),
        .p_ru   (p_ru),
        .p_ld   (p_ld),
        .p_rd   (p_rd),
        .result (red_result),
        .last   (red_last)
    );

    always_comb begin
        n_lu   = p_lu;
        n_ru   = p_ru;
        n_ld   = p_ld;
        n_rd   = p_rd;
        win_wr = 1'b0;
        case (cmd_q)
            CMD_ROT_L: begin
                n_lu = p_ru; n_ru = p_rd; n_rd = p_ld; n_ld = p_lu;
                win_wr = 1'b1;
            end
            CMD_ROT_R: begin
                n_lu = p_ld; n_ru = p_lu; n_rd = p_ru; n_ld = p_rd;
                win_wr = 1'b1;
            end
            CMD_MIRROR_X: begin
                n_lu = p_ld; n_ld = p_lu; n_ru = p_rd; n_rd = p_ru;
                win_wr = 1'b1;
            end
            CMD_MIRROR_Y: begin
                n_lu = p_ru; n_ru = p_lu; n_ld = p_rd; n_rd = p_ld;
                win_wr = 1'b1;
            end
            CMD_INVERT: begin
                n_lu = ~p_lu; n_ru = ~p_ru; n_ld = ~p_ld; n_rd = ~p_rd;
                win_wr = 1'b1;
            end
            CMD_MAX, CMD_MIN, CMD_AVE: begin
                n_lu = red_result; n_ru = red_result;
                n_ld = red_result; n_rd = red_result;
                win_wr = red_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        cmd_d      = cmd_q;
        cap_vld_d  = 1'b0;
        cap_addr_d = cnt_q;
        buf_d      = buf_q;

        // With a registered ROM the pixel for the previous address arrives one cycle late.
        if ((ROM_LAT != 0) && cap_vld_q) begin
            buf_d[cap_addr_q] = IROM_Q;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
            ST_LOAD: begin
                if (ROM_LAT == 0) begin
                    buf_d[cnt_q] = IROM_Q;
                end else begin
                    cap_vld_d = 1'b1;
                end
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = (ROM_LAT != 0) ? ST_DRAIN : ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                state_d = ST_CMD;
            end
            ST_CMD: begin
                if (cmd_valid) begin
                    cmd_d   = cmd;
                    cnt_d   = '0;
                    state_d = (cmd == CMD_WRITE) ? ST_STORE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d   = cnt_q + AW'(1);
                state_d = ST_CMD;
                case (cmd_q)
                    CMD_UP:     if (y_q > YW'(1)) y_d = y_q - YW'(1);
                    CMD_DOWN:   if (y_q < Y_MAX)  y_d = y_q + YW'(1);
                    CMD_LEFT:   if (x_q > XW'(1)) x_d = x_q - XW'(1);
                    CMD_RIGHT:  if (x_q < X_MAX)  x_d = x_q + XW'(1);
                    CMD_ORIGIN: begin
                        x_d = X_CTR;
                        y_d = Y_CTR;
                    end
                    default: ;
                endcase
                if (is_reduce && !red_last) begin
                    state_d = ST_EXEC;
                end
                if (win_wr) begin
                    buf_d[a_lu] = n_lu;
                    buf_d[a_ru] = n_ru;
                    buf_d[a_ld] = n_ld;
                    buf_d[a_rd] = n_rd;
                end
            end
            ST_STORE: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign IROM_rd    = (state_q == ST_LOAD);
    assign IROM_A     = (state_q == ST_LOAD)  ? cnt_q : '0;
    assign IRAM_valid = (state_q == ST_STORE);
    assign IRAM_A     = (state_q == ST_STORE) ? cnt_q : '0;
    assign IRAM_D     = (state_q == ST_STORE) ? buf_q[cnt_q] : '0;
    assign busy       = !((state_q == ST_CMD) || (state_q == ST_DONE));
    assign done       = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            x_q        <= X_CTR;
            y_q        <= Y_CTR;
            cmd_q      <= CMD_WRITE;
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cmd_q      <= cmd_d;
            cap_vld_q  <= cap_vld_d;
            cap_addr_q <= cap_addr_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: an 8x8 ROM_LAT=0 instance and a 16x4 ROM_LAT=1 instance,
// one held in reset while the other is exercised, checked against an array model of the image.
module tb_lcd_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] rom [64];

    logic [7:0] q_a, q_b, d_a, d_b;
    logic [5:0] ia_a, ia_b, ra_a, ra_b;
    logic       rd_a, rd_b, v_a, v_b, busy_a, busy_b, done_a, done_b;

    assign q_a = rom[ia_a];
    always @(posedge clk) q_b <= rom[ia_b];

    lcd_ctrl_param #(.IMG_W(8), .IMG_H(8), .DW(8), .ROM_LAT(0)) dut_a (
        .clk(clk), .reset(rst_a), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(q_a),
        .IROM_rd(rd_a), .IROM_A(ia_a), .IRAM_valid(v_a), .IRAM_D(d_a), .IRAM_A(ra_a),
        .busy(busy_a), .done(done_a)
    );

    lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DW(8), .ROM_LAT(1)) dut_b (
        .clk(clk), .reset(rst_b), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(q_b),
        .IROM_rd(rd_b), .IROM_A(ia_b), .IRAM_valid(v_b), .IRAM_D(d_b), .IRAM_A(ra_b),
        .busy(busy_b), .done(done_b)
    );

    bit         sel = 1'b0;
    logic       s_busy, s_done, s_rd, s_v;
    logic [5:0] s_ia, s_ra;
    logic [7:0] s_d;
    assign s_busy = sel ? busy_b : busy_a;
    assign s_done = sel ? done_b : done_a;
    assign s_rd   = sel ? rd_b   : rd_a;
    assign s_v    = sel ? v_b    : v_a;
    assign s_ia   = sel ? ia_b   : ia_a;
    assign s_ra   = sel ? ra_b   : ra_a;
    assign s_d    = sel ? d_b    : d_a;

    int errors = 0;
    int checks = 0;
    int mw, mh, mx, my;
    int mbuf [64];
    int cap  [64];

    // Image model: plain array plus operation point, updated per command.
    task automatic model_cmd(input int c);
        int rd, ld, ru, lu, a, b, e, f, r;
        rd = my * mw + mx; ld = rd - 1; ru = rd - mw; lu = ru - 1;
        a = mbuf[lu]; b = mbuf[ru]; e = mbuf[ld]; f = mbuf[rd];
        r = -1;
        case (c)
            1:  if (my > 1) my--;
            2:  if (my < mh - 1) my++;
            3:  if (mx > 1) mx--;
            4:  if (mx < mw - 1) mx++;
            5:  begin r = a; if (b > r) r = b; if (e > r) r = e; if (f > r) r = f; end
            6:  begin r = a; if (b < r) r = b; if (e < r) r = e; if (f < r) r = f; end
            7:  r = (a + b + e + f) / 4;
            8:  begin mbuf[lu] = b; mbuf[ru] = f; mbuf[rd] = e; mbuf[ld] = a; end
            9:  begin mbuf[lu] = e; mbuf[ru] = a; mbuf[rd] = b; mbuf[ld] = f; end
            10: begin mbuf[lu] = e; mbuf[ld] = a; mbuf[ru] = f; mbuf[rd] = b; end
            11: begin mbuf[lu] = b; mbuf[ru] = a; mbuf[ld] = f; mbuf[rd] = e; end
            12: begin mx = mw / 2; my = mh / 2; end
            13: begin mbuf[lu] = 255 - a; mbuf[ru] = 255 - b; mbuf[ld] = 255 - e; mbuf[rd] = 255 - f; end
            default: ;
        endcase
        if (r >= 0) begin
            mbuf[lu] = r; mbuf[ru] = r; mbuf[ld] = r; mbuf[rd] = r;
        end
    endtask

    task automatic fill_rom(input bit random);
        for (int i = 0; i < 64; i++) rom[i] = random ? 8'($urandom_range(0, 255)) : 8'(i);
    endtask

    // Reset both, release the selected one and follow its LOAD phase.
    task automatic start_dut(input bit which);
        int  n;
        bit  seq_ok;
        cmd_valid = 1'b0; cmd = 4'd0;
        rst_a = 1'b0; rst_b = 1'b0;
        sel = which;
        mw = which ? 16 : 8; mh = which ? 4 : 8;
        mx = mw / 2; my = mh / 2;
        for (int i = 0; i < 64; i++) mbuf[i] = rom[i];
        repeat (2) @(negedge clk);
        if (which) rst_b = 1'b1; else rst_a = 1'b1;
        n = 0; seq_ok = 1'b1;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (!s_busy) break;
            if (s_done !== 1'b0) seq_ok = 1'b0;
            if (n <= 64) begin
                if (s_rd !== 1'b1 || s_ia !== 6'(n - 1)) seq_ok = 1'b0;
            end else if (s_rd !== 1'b0 || s_ia !== 6'd0) seq_ok = 1'b0;
        end
        checks++;
        if (n != 65 + int'(which)) begin
            errors++;
            $display("FAIL load_latency dut=%0d got %0d cycles, want %0d", which, n, 65 + int'(which));
        end
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL load_sequence dut=%0d IROM_rd/IROM_A/done wrong during LOAD", which);
        end
    endtask

    task automatic send_cmd(input logic [3:0] c, input bit hold_junk);
        int n, exp_len;
        n = 0;
        while (s_busy && n < 100) begin @(negedge clk); n++; end
        cmd = c; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (s_busy && n < 100) begin
            if (hold_junk) begin cmd = 4'd4; cmd_valid = 1'b1; end
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        exp_len = (c >= 4'd5 && c <= 4'd7) ? 4 : 1;
        checks++;
        if (n != exp_len) begin
            errors++;
            $display("FAIL busy_len cmd=%0d got %0d cycles, want %0d", c, n, exp_len);
        end
        model_cmd(int'(c));
    endtask

    task automatic write_check(input string name);
        int bad, bad_k;
        logic [7:0] bad_d;
        logic [5:0] bad_a;
        cmd = 4'd0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        bad = 0; bad_k = 0; bad_d = 0; bad_a = 0;
        for (int k = 0; k < 64; k++) begin
            cap[k] = int'(s_d);
            if (s_v !== 1'b1 || s_ra !== 6'(k) || s_d !== 8'(mbuf[k])) begin
                if (bad == 0) begin bad_k = k; bad_d = s_d; bad_a = s_ra; end
                bad++;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_store beat %0d: IRAM_A=%0d IRAM_D=%0d, want A=%0d D=%0d (%0d bad beats)",
                     name, bad_k, bad_a, bad_d, bad_k, mbuf[bad_k], bad);
        end
        checks++;
        if ({s_done, s_busy, s_v, s_ra} !== {3'b100, 6'd0}) begin
            errors++;
            $display("FAIL %s_done done=%b busy=%b valid=%b A=%0d, want 1 0 0 0",
                     name, s_done, s_busy, s_v, s_ra);
        end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0; cmd = 4'd0;
        rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, rd_a, v_a, ia_a, ra_a, d_a} !== {4'b1000, 6'd0, 6'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_a busy=%b done=%b rd=%b valid=%b IROM_A=%0d IRAM_A=%0d D=%0d, want 1 0 0 0 0 0 0",
                     busy_a, done_a, rd_a, v_a, ia_a, ra_a, d_a);
        end
        checks++;
        if ({busy_b, done_b, rd_b, v_b, ia_b, ra_b, d_b} !== {4'b1000, 6'd0, 6'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_b busy=%b done=%b rd=%b valid=%b IROM_A=%0d IRAM_A=%0d D=%0d, want 1 0 0 0 0 0 0",
                     busy_b, done_b, rd_b, v_b, ia_b, ra_b, d_b);
        end
    endtask

    task automatic test_write_immediate();
        fill_rom(1'b0);
        start_dut(1'b0);
        write_check("write_imm");
    endtask

    task automatic test_reduce();
        logic [3:0] ops [3];
        int         want [3];
        ops[0] = 4'd5; want[0] = 36;
        ops[1] = 4'd7; want[1] = 31;
        ops[2] = 4'd6; want[2] = 27;
        fill_rom(1'b0);
        for (int t = 0; t < 3; t++) begin
            start_dut(1'b0);
            send_cmd(ops[t], 1'b0);
            write_check("reduce");
            checks++;
            if (cap[27] != want[t] || cap[28] != want[t] || cap[35] != want[t] || cap[36] != want[t]) begin
                errors++;
                $display("FAIL reduce_op%0d window=%0d,%0d,%0d,%0d want all %0d",
                         ops[t], cap[27], cap[28], cap[35], cap[36], want[t]);
            end
        end
    endtask

    task automatic test_shift_rot();
        fill_rom(1'b0);
        start_dut(1'b0);
        repeat (5) send_cmd(4'd1, 1'b0);
        repeat (5) send_cmd(4'd3, 1'b0);
        send_cmd(4'd8, 1'b0);
        write_check("shift_rot");
        checks++;
        if (cap[0] != 1 || cap[1] != 9 || cap[9] != 8 || cap[8] != 0) begin
            errors++;
            $display("FAIL clamp_rot_l [0,1,9,8]=%0d,%0d,%0d,%0d want 1,9,8,0", cap[0], cap[1], cap[9], cap[8]);
        end
    endtask

    task automatic test_invert_mirror();
        fill_rom(1'b0);
        start_dut(1'b0);
        send_cmd(4'd13, 1'b0);
        write_check("invert");
        checks++;
        if (cap[27] != 228) begin
            errors++;
            $display("FAIL invert_27 got %0d want 228", cap[27]);
        end
        start_dut(1'b0);
        send_cmd(4'd4, 1'b0);
        send_cmd(4'd4, 1'b0);
        send_cmd(4'd12, 1'b0);
        send_cmd(4'd11, 1'b0);
        write_check("origin_mirror");
        checks++;
        if (cap[27] != 28 || cap[28] != 27 || cap[35] != 36 || cap[36] != 35) begin
            errors++;
            $display("FAIL origin_mirror_y [27,28,35,36]=%0d,%0d,%0d,%0d want 28,27,36,35",
                     cap[27], cap[28], cap[35], cap[36]);
        end
    endtask

    task automatic test_rom_lat1();
        fill_rom(1'b0);
        start_dut(1'b1);
        send_cmd(4'd5, 1'b0);
        write_check("lat1_max");
        checks++;
        if (cap[23] != 40 || cap[24] != 40 || cap[39] != 40 || cap[40] != 40) begin
            errors++;
            $display("FAIL lat1_window [23,24,39,40]=%0d,%0d,%0d,%0d want all 40",
                     cap[23], cap[24], cap[39], cap[40]);
        end
    endtask

    task automatic test_busy_ignore();
        fill_rom(1'b1);
        start_dut(1'b0);
        send_cmd(4'd5, 1'b1);
        send_cmd(4'd9, 1'b1);
        send_cmd(4'd7, 1'b1);
        write_check("busy_ignore");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_rom(1'b1);
            start_dut(r[0]);
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_cmd(4'($urandom_range(1, 15)), 1'b0);
            end
            write_check("random");
        end
    endtask

    task automatic test_reset_mid_store();
        int n;
        fill_rom(1'b0);
        start_dut(1'b0);
        send_cmd(4'd2, 1'b0);
        cmd = 4'd0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (s_ra !== 6'd20 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (s_ra !== 6'd20 || s_v !== 1'b1) begin
            errors++;
            $display("FAIL mid_store_reach IRAM_A=%0d valid=%b, want 20 1", s_ra, s_v);
        end
        rst_a = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, rd_a, v_a, ia_a, ra_a, d_a} !== {4'b1000, 6'd0, 6'd0, 8'd0}) begin
            errors++;
            $display("FAIL mid_store_reset busy=%b done=%b rd=%b valid=%b IROM_A=%0d IRAM_A=%0d D=%0d, want 1 0 0 0 0 0 0",
                     busy_a, done_a, rd_a, v_a, ia_a, ra_a, d_a);
        end
        start_dut(1'b0);
        checks++;
        if (s_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_store_done_low done=%b want 0", s_done);
        end
        write_check("after_reset");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; cmd = 4'd0; cmd_valid = 1'b0;
        fill_rom(1'b0);
        test_reset();
        test_write_immediate();
        test_reduce();
        test_shift_rot();
        test_invert_mirror();
        test_rom_lat1();
        test_busy_ignore();
        test_random();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
